// File: rtl/pipe_adder_seg.sv
// Segmented carry-pipelined adder/subtractor with valid/ready flow control.
// Segment k of the sum is resolved in stage k from the carry registered by stage k-1.
module pipe_adder_seg #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder_seg: WIDTH must be >= 2 and a multiple of STAGES");
    end

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

    logic stall;
    logic adv;

    // Inputs seen by segment k, and what segment k produces.
    logic [WIDTH-1:0] seg_a [STAGES];
    logic [WIDTH-1:0] seg_b [STAGES];
    logic [WIDTH-1:0] seg_s [STAGES];
    logic             seg_c [STAGES];
    logic             seg_v [STAGES];
    logic [WIDTH-1:0] res_s [STAGES];
    logic             res_c [STAGES];

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = rst_n & ~stall;

    // Subtraction folds into the add as A + ~B + 1; cin is ignored then.
    assign seg_a[0] = a;
    assign seg_b[0] = sub ? ~b : b;
    assign seg_s[0] = '0;
    assign seg_c[0] = sub | cin;
    assign seg_v[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [SEG:0] t;

        assign t = {1'b0, seg_a[k][k*SEG +: SEG]}
                 + {1'b0, seg_b[k][k*SEG +: SEG]}
                 + (SEG+1)'(seg_c[k]);

        assign res_s[k] = (seg_s[k] & ~(SEG_MASK << (k*SEG)))
                        | (WIDTH'(t[SEG-1:0]) << (k*SEG));
        assign res_c[k] = t[SEG];

        if (k < LAST) begin : g_reg
            logic             r_v;
            logic             r_c;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                end else if (adv) begin
                    r_v <= seg_v[k];
                    if (seg_v[k]) begin
                        r_c <= res_c[k];
                        r_a <= seg_a[k];
                        r_b <= seg_b[k];
                        r_s <= res_s[k];
                    end
                end
            end

            assign seg_a[k+1] = r_a;
            assign seg_b[k+1] = r_b;
            assign seg_s[k+1] = r_s;
            assign seg_c[k+1] = r_c;
            assign seg_v[k+1] = r_v;
        end
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat_sum;
    logic             a_msb;
    logic             raw_ovf;

    assign raw     = res_s[LAST];
    assign a_msb   = seg_a[LAST][WIDTH-1];
    assign raw_ovf = (a_msb == seg_b[LAST][WIDTH-1]) && (raw[WIDTH-1] != a_msb);

    // Overflow direction follows the operand sign: positive clamps to 0111..1.
    assign sat_sum = (SAT_EN && raw_ovf) ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= seg_v[LAST];
            if (seg_v[LAST]) begin
                sum  <= sat_sum;
                cout <= res_c[LAST];
                ovf  <= raw_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder_seg.sv
// Directed and randomized checks of pipe_adder_seg across several configurations.
module tb_pipe_adder_seg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, cin, sub, out_ready;
    logic [7:0] a, b;

    logic       in_ready0, out_valid0, cout0, ovf0;
    logic [7:0] sum0;
    logic       in_ready1, out_valid1, cout1, ovf1;
    logic [7:0] sum1;

    logic        rv, rc, rs, ro;
    logic [15:0] ra, rb;
    logic        in_ready2, out_valid2, cout2, ovf2;
    logic [15:0] sum2;
    logic        in_ready3, out_valid3, cout3, ovf3;
    logic [7:0]  sum3;

    int checks = 0;
    int errors = 0;
    logic [17:0] q2[$];
    logic [17:0] q3[$];

    pipe_adder_seg #(.WIDTH(8), .STAGES(2), .SAT_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid0),
        .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    pipe_adder_seg #(.WIDTH(8), .STAGES(2), .SAT_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    pipe_adder_seg #(.WIDTH(16), .STAGES(4), .SAT_EN(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(in_ready2),
        .a(ra), .b(rb), .cin(rc), .sub(rs), .out_valid(out_valid2),
        .out_ready(ro), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    pipe_adder_seg #(.WIDTH(8), .STAGES(1), .SAT_EN(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(in_ready3),
        .a(ra[7:0]), .b(rb[7:0]), .cin(rc), .sub(rs), .out_valid(out_valid3),
        .out_ready(ro), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ref_add(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic c,
                                            input logic s);
        logic [15:0] m, xw, yb;
        logic [16:0] full;
        logic        ov;
        m    = (w == 16) ? 16'hFFFF : 16'h00FF;
        xw   = x & m;
        yb   = (s ? ~y : y) & m;
        full = {1'b0, xw} + {1'b0, yb} + {16'd0, (s ? 1'b1 : c)};
        ov   = (xw[w-1] == yb[w-1]) && (full[w-1] != xw[w-1]);
        return {ov, full[w], full[15:0] & m};
    endfunction

    task automatic drive(input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic s);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    endtask

    task automatic beat(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic s, input logic [7:0] es,
                        input logic ec, input logic eo, input logic [7:0] esat);
        @(negedge clk);
        drive(x, y, c, s);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat"}, out_valid0, 0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid0, 1);
        chk({tag, "_sum"}, sum0, es);
        chk({tag, "_cout"}, cout0, ec);
        chk({tag, "_ovf"}, ovf0, eo);
        chk({tag, "_satsum"}, sum1, esat);
        chk({tag, "_satovf"}, ovf1, eo);
        chk({tag, "_satcout"}, cout1, ec);
    endtask

    task automatic rand_step();
        logic [17:0] e;
        if (rv && in_ready2) q2.push_back(ref_add(16, ra, rb, rc, rs));
        if (rv && in_ready3) q3.push_back(ref_add(8, ra, rb, rc, rs));
        if (out_valid2 && ro) begin
            chk("u2_nonempty", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("u2_res", {ovf2, cout2, sum2}, e);
            end
        end
        if (out_valid3 && ro) begin
            chk("u3_nonempty", q3.size() != 0, 1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("u3_res", {ovf3, cout3, 8'h00, sum3}, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rv = 1'b0; ro = 1'b1; ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        #1;
        chk("rst_ovld", out_valid0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cout", cout0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_irdy", in_ready0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_irdy", in_ready0, 1);

        beat("ff_p_00", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        beat("05_m_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8'hFE);
        beat("07_m_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h02);
        beat("7f_p_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h7F);
        beat("80_m_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80);
        beat("3c_p_41", 8'h3C, 8'h41, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h7E);
        @(negedge clk);
        chk("hold_vld", out_valid0, 0);
        chk("hold_sum", sum0, 8'h7E);

        drive(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h02, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_b1_vld", out_valid0, 1);
        chk("st_b1_sum", sum0, 8'h02);
        drive(8'h03, 8'h03, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("st_irdy_c2", in_ready0, 0);
        @(negedge clk);
        chk("st_irdy_c3", in_ready0, 0);
        chk("st_sum_c3", sum0, 8'h02);
        @(negedge clk);
        chk("st_irdy_c4", in_ready0, 0);
        chk("st_vld_c4", out_valid0, 1);
        chk("st_sum_c4", sum0, 8'h02);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("st_irdy_go", in_ready0, 1);
        chk("st_sum_go", sum0, 8'h02);
        @(negedge clk);
        chk("st_b2_sum", sum0, 8'h04);
        drive(8'h04, 8'h04, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("st_b3_sum", sum0, 8'h06);
        @(negedge clk);
        chk("st_b4_vld", out_valid0, 1);
        chk("st_b4_sum", sum0, 8'h08);
        @(negedge clk);
        chk("st_empty", out_valid0, 0);

        drive(8'h11, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h22, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rr_pre_sum", sum0, 8'h22);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_ovld", out_valid0, 0);
        chk("rr_sum", sum0, 0);
        chk("rr_irdy", in_ready0, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rr_stale1", out_valid0, 0);
        @(negedge clk);
        chk("rr_stale2", out_valid0, 0);
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rr_new_lat", out_valid0, 0);
        @(negedge clk);
        chk("rr_new_vld", out_valid0, 1);
        chk("rr_new_sum", sum0, 8'h30);

        for (int i = 0; i < 800; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 3) != 0);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            #1;
            rand_step();
            @(negedge clk);
        end
        rv = 1'b0;
        ro = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            rand_step();
            @(negedge clk);
        end
        chk("u2_drained", q2.size(), 0);
        chk("u3_drained", q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
